load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage for the RV32I core; sits directly upstream of the load data converter.
- On `start`, decodes IR (loads `0000011`, stores `0100011`), issues one word-aligned request on the data-memory bus, and handles the request/ready and rvalid handshakes.
- For loads, latches the raw 32-bit word, byte offset and IR as a stable bundle that feeds the load data converter.
- For stores, generates lane-replicated write data and byte enables.

Parameters:
- `TIMEOUT`, 16: maximum cycles waiting for `mem_rvalid` or `mem_ready` before aborting with `err`.
- `TCW`, 5: timeout counter width; must satisfy 2^TCW > TIMEOUT.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: one-cycle request to execute the instruction in `ir`; accepted only in IDLE.
- `ir` in 32: instruction register value; sampled at accepted `start`.
- `addr` in 32: effective byte address (rs1+imm); sampled at accepted `start`.
- `st_data` in 32: rs2 value for stores; sampled at accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = timeout (or misalignment when the optional feature is enabled).
- `ld_word` out 32: raw memory word, held until next load completes.
- `ld_offset` out 2: `addr[1:0]` of the latched load.
- `ld_ir` out 32: IR of the latched load.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables (writes only; 4'b0000 on reads).
- `mem_wdata` out 32: write data.
- `mem_ready` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.

Behaviour:
- Reset (async, immediate): state=IDLE; counter=0; all outputs 0, including `mem_req` (drops asynchronously mid-transaction); `ld_word`/`ld_offset`/`ld_ir`=0.
- States: IDLE, REQ, RWAIT, DONE.
- IDLE:
  - `start`=1 with a load/store opcode → latch `ir`, `addr`, `st_data`; go to REQ.
  - `start`=1 with any other opcode → DONE (no bus access, `err`=0).
  - `start` outside IDLE is ignored.
- REQ:
  - `mem_req`=1; `mem_addr`/`mem_we`/`mem_be`/`mem_wdata` held stable until `mem_ready`.
  - Load with `mem_ready` → RWAIT.
  - Store with `mem_ready` → DONE.
  - Counter reaching `TIMEOUT` first → DONE with `err`=1.
- RWAIT:
  - `mem_req`=0.
  - On `mem_rvalid`: `ld_word`←`mem_rdata`, `ld_offset`←`addr[1:0]`, `ld_ir`←`ir`; go to DONE.
  - Timeout → DONE with `err`=1; `ld_*` unchanged.
  - `mem_rvalid` arriving in the same cycle as the timeout: data wins, `err`=0.
- DONE: `done`=1 for exactly one cycle → IDLE. `mem_rvalid` outside RWAIT is ignored.
- Counter: clears on every state entry; increments in REQ/RWAIT; saturates at `TIMEOUT`.
- Minimum latency: load start→done 3 cycles with ready and rvalid both immediate; store 2 cycles.
- Store formatting by `funct3`; `o`=`addr[1:0]`:
  - SB (000): `wdata`={4{rs2[7:0]}}, `be`=4'b0001<<o.
  - SH (001): `wdata`={2{rs2[15:0]}}, `be`=o[1]?4'b1100:4'b0011.
  - SW (010): `wdata`=rs2, `be`=4'b1111.
  - Any other store funct3: `be`=0, access still performed.
- Loads never alter `ld_*` except on a successful `mem_rvalid`. `ld_*` holds across IDLE for the downstream converter.

Optional Feature:
- Macro: `LSU_MISALIGN_CHECK_EN`.
- Defined: in IDLE, halfword access with `addr[0]`=1, or word access with `addr[1:0]`≠0, goes straight to DONE with `err`=1. No `mem_req` is raised and `ld_*` is unchanged.
- Undefined: no check. Halfword uses `addr[1]` only, word ignores `addr[1:0]`; access proceeds normally.

Test Plan:
- LW `addr`=0x100, `mem_ready` at REQ cycle 1, `mem_rvalid` 2 cycles later with `rdata`=0xDEADBEEF → `mem_addr`=0x100, `ld_word`=0xDEADBEEF, `ld_offset`=0, single `done`, `err`=0.
- SB `addr`=0x203, `st_data`=0x000000A5, `mem_ready` immediate → `mem_be`=4'b1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x200, `done` 2 cycles after `start`.
- SH `addr`=0x22, `st_data`=0x1234 → `mem_be`=4'b1100, `mem_wdata`=0x12341234.
- LBU, `mem_rvalid` never asserted, `TIMEOUT`=16 → `done`+`err` 16 cycles after entering RWAIT; `ld_word` keeps its previous value; second `start` while `busy` ignored.
- `rst` pulsed while in REQ → `mem_req`, `busy` drop the same cycle without a clock edge; next LW completes normally.
- With `LSU_MISALIGN_CHECK_EN`: LW `addr`=0x102 → no `mem_req`, `done`+`err` 1 cycle after `start`. Without the macro: access to 0x100 proceeds.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store bus stage; optional misalignment trap via LSU_MISALIGN_CHECK_EN
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int TCW = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] ld_word,
  output logic [1:0]  ld_offset,
  output logic [31:0] ld_ir,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [TCW-1:0] cnt_q, cnt_d;
  logic [31:0] ir_q, ir_d, addr_q, addr_d, sd_q, sd_d;
  logic [31:0] ld_word_d, ld_ir_d;
  logic [1:0] ld_offset_d;
  logic fail, is_mem, mis, tmo, req_d, st_d;
  logic busy_d, done_d, err_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d, wd;
  logic [3:0] mem_be_d, be_st;
  logic [2:0] f3;
  logic [1:0] o;
  assign is_mem = ir[6:0] == 7'b0000011 || ir[6:0] == 7'b0100011;
`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = (ir[13:12] == 2'b01 && addr[0]) || (ir[13:12] == 2'b10 && addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign tmo = cnt_q == TCW'(TIMEOUT - 1);
  // next-state, operand latching and load-bundle capture
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    addr_d = addr_q;
    sd_d = sd_q;
    ld_word_d = ld_word;
    ld_offset_d = ld_offset;
    ld_ir_d = ld_ir;
    fail = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        ir_d = ir;
        addr_d = addr;
        sd_d = st_data;
        state_d = is_mem && !mis ? REQ : DONE;
        fail = is_mem && mis;
      end
      REQ: if (mem_ready) state_d = ir_q[5] ? DONE : RWAIT;
      else if (tmo) begin
        state_d = DONE;
        fail = 1'b1;
      end
      RWAIT: if (mem_rvalid) begin
        ld_word_d = mem_rdata;
        ld_offset_d = addr_q[1:0];
        ld_ir_d = ir_q;
        state_d = DONE;
      end else if (tmo) begin
        state_d = DONE;
        fail = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // bus outputs and status derived from the next state so they leave the flops cleanly
  always_comb begin
    f3 = ir_d[14:12];
    o = addr_d[1:0];
    be_st = f3 == 3'b000 ? 4'b0001 << o : f3 == 3'b001 ? (o[1] ? 4'b1100 : 4'b0011) : f3 == 3'b010 ? 4'b1111 : 4'b0000;
    wd = f3 == 3'b000 ? {4{sd_d[7:0]}} : f3 == 3'b001 ? {2{sd_d[15:0]}} : sd_d;
    req_d = state_d == REQ;
    st_d = req_d && ir_d[5];
    mem_we_d = st_d;
    mem_addr_d = req_d ? {addr_d[31:2], 2'b00} : 32'h0;
    mem_be_d = st_d ? be_st : 4'b0000;
    mem_wdata_d = st_d ? wd : 32'h0;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    err_d = done_d && fail;
    cnt_d = state_d != state_q ? '0 : (state_q == REQ || state_q == RWAIT) && cnt_q != TCW'(TIMEOUT) ? cnt_q + 1'b1 : cnt_q;
  end
  // all state and registered outputs, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ir_q <= '0;
      addr_q <= '0;
      sd_q <= '0;
      ld_word <= '0;
      ld_offset <= '0;
      ld_ir <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ir_q <= ir_d;
      addr_q <= addr_d;
      sd_q <= sd_d;
      ld_word <= ld_word_d;
      ld_offset <= ld_offset_d;
      ld_ir <= ld_ir_d;
      busy <= busy_d;
      done <= done_d;
      err <= err_d;
      mem_req <= req_d;
      mem_we <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_be <= mem_be_d;
      mem_wdata <= mem_wdata_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed check of load_store_unit with a small reactive memory
module tb_load_store_unit;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] ir = 0, addr = 0, st_data = 0, mem_rdata = 0;
  logic mem_ready = 0, mem_rvalid = 0;
  logic busy, done, err, mem_req, mem_we;
  logic [31:0] ld_word, ld_ir, mem_addr, mem_wdata;
  logic [1:0] ld_offset;
  logic [3:0] mem_be;
  int errors = 0, checks = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .addr(addr), .st_data(st_data),
    .busy(busy), .done(done), .err(err), .ld_word(ld_word), .ld_offset(ld_offset), .ld_ir(ld_ir),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, addr, sd;
    int rdy, rv;
    logic [31:0] rdata;
    bit req;
    logic [31:0] maddr;
    bit we;
    logic [3:0] be;
    logic [31:0] wd;
    int lat;
    bit err;
    logic [31:0] ldw;
    logic [1:0] ldo;
    logic [31:0] ldi;
  } vec_t;
  vec_t tv[12];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(int idx, vec_t v);
    int cyc = 0, reqc = 0, rwc = 0, lat = 0;
    bit got = 0, acc = 0, seen = 0;
    logic e = 0, we_s = 0;
    logic [31:0] ma = 0, wd_s = 0;
    logic [3:0] be_s = 0;
    @(negedge clk);
    ir = v.ir; addr = v.addr; st_data = v.sd; start = 1;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = cyc == 3;
      mem_ready = 0;
      mem_rvalid = 0;
      if (cyc == 1) chk($sformatf("v%0d busy", idx), busy, 1);
      if (done) begin
        got = 1; lat = cyc; e = err;
      end else if (mem_req) begin
        if (!seen) begin
          seen = 1; ma = mem_addr; we_s = mem_we; be_s = mem_be; wd_s = mem_wdata;
        end
        mem_ready = reqc >= v.rdy;
        acc |= mem_ready;
        reqc++;
      end else if (acc) begin
        mem_rvalid = rwc == v.rv;
        mem_rdata = v.rdata;
        rwc++;
      end
    end
    if (!got) chk($sformatf("v%0d done_seen", idx), 0, 1);
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d err", idx), e, v.err);
    chk($sformatf("v%0d req_seen", idx), seen, v.req);
    if (v.req) begin
      chk($sformatf("v%0d mem_addr", idx), ma, v.maddr);
      chk($sformatf("v%0d mem_we", idx), we_s, v.we);
      chk($sformatf("v%0d mem_be", idx), be_s, v.be);
      if (v.be != 0) chk($sformatf("v%0d mem_wdata", idx), wd_s, v.wd);
    end
    chk($sformatf("v%0d ld_word", idx), ld_word, v.ldw);
    chk($sformatf("v%0d ld_offset", idx), ld_offset, v.ldo);
    chk($sformatf("v%0d ld_ir", idx), ld_ir, v.ldi);
    @(negedge clk);
    start = 0;
    chk($sformatf("v%0d done_pulse", idx), done, 0);
    chk($sformatf("v%0d idle", idx), busy, 0);
  endtask

  initial begin
    //         ir            addr          sd            rdy   rv  rdata         req maddr        we be       wdata         lat err ldw           ldo   ldi
    tv[0]  = '{32'h00002003, 32'h00000100, 32'h0,        0,    1,  32'hDEADBEEF, 1, 32'h00000100, 0, 4'b0000, 32'h0,        4,  0, 32'hDEADBEEF, 2'd0, 32'h00002003};
    tv[1]  = '{32'h00000023, 32'h00000203, 32'h000000A5, 0,    0,  32'h0,        1, 32'h00000200, 1, 4'b1000, 32'hA5A5A5A5, 2,  0, 32'hDEADBEEF, 2'd0, 32'h00002003};
    tv[2]  = '{32'h00001023, 32'h00000022, 32'h00001234, 0,    0,  32'h0,        1, 32'h00000020, 1, 4'b1100, 32'h12341234, 2,  0, 32'hDEADBEEF, 2'd0, 32'h00002003};
    tv[3]  = '{32'h00002023, 32'h00000010, 32'hCAFEF00D, 2,    0,  32'h0,        1, 32'h00000010, 1, 4'b1111, 32'hCAFEF00D, 4,  0, 32'hDEADBEEF, 2'd0, 32'h00002003};
    tv[4]  = '{32'h00004003, 32'h00000047, 32'h0,        0,    0,  32'h11223344, 1, 32'h00000044, 0, 4'b0000, 32'h0,        3,  0, 32'h11223344, 2'd3, 32'h00004003};
    tv[5]  = '{32'h00004003, 32'h00000051, 32'h0,        0,    -1, 32'h99999999, 1, 32'h00000050, 0, 4'b0000, 32'h0,        18, 1, 32'h11223344, 2'd3, 32'h00004003};
    tv[6]  = '{32'h00001003, 32'h00000062, 32'h0,        1000, 0,  32'h0,        1, 32'h00000060, 0, 4'b0000, 32'h0,        17, 1, 32'h11223344, 2'd3, 32'h00004003};
    tv[7]  = '{32'h00002003, 32'h00000080, 32'h0,        0,    15, 32'h55AA55AA, 1, 32'h00000080, 0, 4'b0000, 32'h0,        18, 0, 32'h55AA55AA, 2'd0, 32'h00002003};
    tv[8]  = '{32'h00003023, 32'h00000013, 32'h00000077, 0,    0,  32'h0,        1, 32'h00000010, 1, 4'b0000, 32'h0,        2,  0, 32'h55AA55AA, 2'd0, 32'h00002003};
    tv[9]  = '{32'h00000013, 32'h00000100, 32'h0,        0,    0,  32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        1,  0, 32'h55AA55AA, 2'd0, 32'h00002003};
`ifdef LSU_MISALIGN_CHECK_EN
    tv[10] = '{32'h00002003, 32'h00000102, 32'h0,        0,    0,  32'h0BADF00D, 0, 32'h0,        0, 4'b0000, 32'h0,        1,  1, 32'h55AA55AA, 2'd0, 32'h00002003};
    tv[11] = '{32'h00001023, 32'h00000021, 32'h0000BEEF, 0,    0,  32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        1,  1, 32'h55AA55AA, 2'd0, 32'h00002003};
`else
    tv[10] = '{32'h00002003, 32'h00000102, 32'h0,        0,    0,  32'h0BADF00D, 1, 32'h00000100, 0, 4'b0000, 32'h0,        3,  0, 32'h0BADF00D, 2'd2, 32'h00002003};
    tv[11] = '{32'h00001023, 32'h00000021, 32'h0000BEEF, 0,    0,  32'h0,        1, 32'h00000020, 1, 4'b0011, 32'hBEEFBEEF, 2,  0, 32'h0BADF00D, 2'd2, 32'h00002003};
`endif
    #2;
    chk("rst mem_req", mem_req, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst ld_word", ld_word, 0);
    chk("rst ld_ir", ld_ir, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 12; i++) run(i, tv[i]);
    @(negedge clk);
    ir = 32'h00002003; addr = 32'h00000300; start = 1;
    @(negedge clk);
    start = 0;
    chk("mid mem_req", mem_req, 1);
    #2 rst = 1;
    #1;
    chk("async mem_req", mem_req, 0);
    chk("async busy", busy, 0);
    chk("async ld_word", ld_word, 0);
    @(negedge clk);
    rst = 0;
    tv[0].ldw = 32'hDEADBEEF;
    run(100, tv[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
